// File: rtl/stream_mux_rr.sv
// N-to-1 stream multiplexer with a one-word registered output stage.
// Arbitration is round-robin (RR=1) or fixed lowest-index priority (RR=0).
module stream_mux_rr #(
  parameter int N  = 4,
  parameter int W  = 4,
  parameter int RR = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*W-1:0]       in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_sel,
  input  logic                 out_ready
);
  localparam int SW = $clog2(N);

  logic          out_valid_r;
  logic [W-1:0]  out_data_r;
  logic [SW-1:0] out_sel_r;
  logic [SW-1:0] ptr_r;

  logic          load_s;
  logic          xfer_s;
  logic [N-1:0]  grant_s;
  logic [SW-1:0] gidx_s;
  logic          found_s;
  logic [W-1:0]  sel_data_s;
  logic [SW-1:0] nxt_ptr_s;

  assign load_s   = !out_valid_r || out_ready;
  // Reset also blanks in_ready combinationally, so nothing is accepted while rst_n is low.
  assign in_ready = grant_s & {N{rst_n}};
  assign xfer_s   = |in_ready;

  // First-valid search starting at ptr_r with wrap; ptr_r stays 0 in fixed-priority mode.
  always_comb begin
    logic [SW:0]   sum_v;
    logic [SW-1:0] idx_v;
    logic          hit_v;
    grant_s = '0;
    gidx_s  = '0;
    found_s = 1'b0;
    sum_v   = '0;
    idx_v   = '0;
    hit_v   = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum_v = {1'b0, ptr_r} + (SW+1)'(k);
      sum_v = (sum_v >= (SW+1)'(N)) ? (sum_v - (SW+1)'(N)) : sum_v;
      idx_v = sum_v[SW-1:0];
      hit_v = !found_s && load_s && in_valid[idx_v];
      grant_s[idx_v] = grant_s[idx_v] | hit_v;
      gidx_s  = hit_v ? idx_v : gidx_s;
      found_s = found_s | hit_v;
    end
  end

  // AND-OR select keeps unknowns on ungranted channels out of the datapath.
  always_comb begin
    sel_data_s = '0;
    for (int k = 0; k < N; k++) begin
      sel_data_s = sel_data_s | (in_data[k*W +: W] & {W{grant_s[k]}});
    end
  end

  assign nxt_ptr_s = (gidx_s == SW'(N-1)) ? '0 : (gidx_s + SW'(1));

  // Output register and round-robin pointer; an idle load slot empties the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sel_r   <= '0;
      ptr_r       <= '0;
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= sel_data_s;
      out_sel_r   <= gidx_s;
      ptr_r       <= (RR != 0) ? nxt_ptr_s : '0;
    end else if (load_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a round-robin and a fixed-priority instance share stimulus;
// a vector table plus a per-instance scoreboard of expected output words.
module tb_stream_mux_rr;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic [3:0]  rdy_rr, rdy_fp;
  logic        ov_rr, ov_fp;
  logic [3:0]  od_rr, od_fp;
  logic [1:0]  os_rr, os_fp;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] data;
    logic [1:0] sel;
  } exp_t;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] data;
    logic        oready;
    logic [3:0]  rdy_rr;
    logic [3:0]  rdy_fp;
  } vec_t;

  exp_t q_rr[$];
  exp_t q_fp[$];
  exp_t last_rr, last_fp;
  vec_t tbl[21];

  always #5 clk = ~clk;

  stream_mux_rr #(.N(4), .W(4), .RR(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_rr), .out_valid(ov_rr), .out_data(od_rr), .out_sel(os_rr),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.N(4), .W(4), .RR(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_fp), .out_valid(ov_fp), .out_data(od_fp), .out_sel(os_fp),
    .out_ready(out_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One scoreboard step for instance d (0 = round-robin, 1 = fixed priority).
  task automatic sb_step(input int d, input logic [3:0] rdy, input logic ov,
                         input logic [3:0] od, input logic [1:0] os,
                         input logic [3:0] exp_rdy, input logic [15:0] data,
                         input logic ordy);
    string nm;
    exp_t  fr, lst, e;
    bit    has;
    nm  = (d == 0) ? "rr" : "fp";
    has = (d == 0) ? (q_rr.size() > 0) : (q_fp.size() > 0);
    lst = (d == 0) ? last_rr : last_fp;
    chk({nm, ".in_ready"}, {28'd0, rdy}, {28'd0, exp_rdy});
    if (has) begin
      fr = (d == 0) ? q_rr[0] : q_fp[0];
      chk({nm, ".out_valid"}, {31'd0, ov}, 32'd1);
      chk({nm, ".out_data"}, {28'd0, od}, {28'd0, fr.data});
      chk({nm, ".out_sel"}, {30'd0, os}, {30'd0, fr.sel});
      chk({nm, ".out_data_known"}, {31'd0, $isunknown(od)}, 32'd0);
      if (ordy) begin
        if (d == 0) begin last_rr = fr; void'(q_rr.pop_front()); end
        else        begin last_fp = fr; void'(q_fp.pop_front()); end
      end
    end else begin
      chk({nm, ".out_valid_idle"}, {31'd0, ov}, 32'd0);
      chk({nm, ".out_data_hold"}, {28'd0, od}, {28'd0, lst.data});
      chk({nm, ".out_sel_hold"}, {30'd0, os}, {30'd0, lst.sel});
    end
    for (int k = 0; k < 4; k++) begin
      if (exp_rdy[k]) begin
        e.sel  = 2'(k);
        e.data = data[k*4 +: 4];
        if (d == 0) q_rr.push_back(e);
        else        q_fp.push_back(e);
      end
    end
  endtask

  task automatic run_cycle(input logic [3:0] v, input logic [15:0] d, input logic ordy,
                           input logic [3:0] e_rr, input logic [3:0] e_fp);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    sb_step(0, rdy_rr, ov_rr, od_rr, os_rr, e_rr, d, ordy);
    sb_step(1, rdy_fp, ov_fp, od_fp, os_fp, e_fp, d, ordy);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".rr_ready"}, {28'd0, rdy_rr}, 32'd0);
    chk({tag, ".fp_ready"}, {28'd0, rdy_fp}, 32'd0);
    chk({tag, ".rr_valid"}, {31'd0, ov_rr}, 32'd0);
    chk({tag, ".fp_valid"}, {31'd0, ov_fp}, 32'd0);
    chk({tag, ".rr_data"}, {28'd0, od_rr}, 32'd0);
    chk({tag, ".rr_sel"}, {30'd0, os_rr}, 32'd0);
    chk({tag, ".fp_data"}, {28'd0, od_fp}, 32'd0);
    chk({tag, ".fp_sel"}, {30'd0, os_fp}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_data   = 16'hdcba;
    out_ready = 1'b1;
    last_rr   = '{4'h0, 2'd0};
    last_fp   = '{4'h0, 2'd0};

    tbl[0]  = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0100, 16'h0c00, 1'b1, 4'b0100, 4'b0100};
    tbl[2]  = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b1000, 16'hd000, 1'b1, 4'b1000, 4'b1000};
    tbl[4]  = '{4'b1111, 16'hdcba, 1'b1, 4'b0001, 4'b0001};
    tbl[5]  = '{4'b1111, 16'hdcba, 1'b1, 4'b0010, 4'b0001};
    tbl[6]  = '{4'b1111, 16'hdcba, 1'b1, 4'b0100, 4'b0001};
    tbl[7]  = '{4'b1111, 16'hdcba, 1'b1, 4'b1000, 4'b0001};
    tbl[8]  = '{4'b1111, 16'hdcba, 1'b1, 4'b0001, 4'b0001};
    tbl[9]  = '{4'b1111, 16'hdcba, 1'b1, 4'b0010, 4'b0001};
    tbl[10] = '{4'b1111, 16'hdcba, 1'b1, 4'b0100, 4'b0001};
    tbl[11] = '{4'b1111, 16'hdcba, 1'b1, 4'b1000, 4'b0001};
    tbl[12] = '{4'b0010, 16'h00b0, 1'b1, 4'b0010, 4'b0010};
    tbl[13] = '{4'b1111, 16'hdcba, 1'b0, 4'b0000, 4'b0000};
    tbl[14] = '{4'b0101, 16'h5a5a, 1'b0, 4'b0000, 4'b0000};
    tbl[15] = '{4'b1000, 16'hffff, 1'b0, 4'b0000, 4'b0000};
    tbl[16] = '{4'b1111, 16'hdcba, 1'b1, 4'b0100, 4'b0001};
    tbl[17] = '{4'b1010, 16'hd0b0, 1'b1, 4'b1000, 4'b0010};
    tbl[18] = '{4'b1010, 16'bxxxx000010110000, 1'b1, 4'b0010, 4'b0010};
    tbl[19] = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 4'b0000};
    tbl[20] = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 4'b0000};

    #12;
    chk_reset("por");
    @(posedge clk);
    #1;
    in_valid = 4'b0000;
    in_data  = 16'h0000;
    rst_n    = 1'b1;

    foreach (tbl[i]) begin
      run_cycle(tbl[i].valid, tbl[i].data, tbl[i].oready, tbl[i].rdy_rr, tbl[i].rdy_fp);
    end

    // Mid-stream reset pulse between edges, with words in flight.
    run_cycle(4'b1111, 16'hdcba, 1'b1, 4'b0100, 4'b0001);
    run_cycle(4'b1111, 16'hdcba, 1'b1, 4'b1000, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    q_rr.delete();
    q_fp.delete();
    last_rr = '{4'h0, 2'd0};
    last_fp = '{4'h0, 2'd0};
    @(posedge clk);
    #1;
    in_valid = 4'b0000;
    in_data  = 16'h0000;
    rst_n    = 1'b1;
    run_cycle(4'b0000, 16'h0000, 1'b1, 4'b0000, 4'b0000);
    run_cycle(4'b1111, 16'h7654, 1'b1, 4'b0001, 4'b0001);
    run_cycle(4'b0000, 16'h0000, 1'b1, 4'b0000, 4'b0000);
    run_cycle(4'b0000, 16'h0000, 1'b1, 4'b0000, 4'b0000);

    chk("rr.sb_empty", q_rr.size(), 32'd0);
    chk("fp.sb_empty", q_fp.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
